// File: rtl/grid_scan_pkg.sv
// Shared types and constants for the row-multiplexed grid display scanner.
package grid_scan_pkg;

    localparam int GRID_W = 64;
    localparam int ROWS   = 8;
    localparam int COLS   = 8;
    localparam int ROW_W  = $clog2(ROWS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_SHOW  = 2'd2
    } scan_state_e;

    function automatic logic [ROWS-1:0] row_off(input bit active_low);
        if (active_low) begin
            return {ROWS{1'b1}};
        end else begin
            return {ROWS{1'b0}};
        end
    endfunction

    function automatic logic [ROWS-1:0] row_on(input logic [ROW_W-1:0] row, input bit active_low);
        logic [ROWS-1:0] onehot;
        onehot = {{(ROWS-1){1'b0}}, 1'b1} << row;
        if (active_low) begin
            return ~onehot;
        end else begin
            return onehot;
        end
    endfunction

endpackage

// File: rtl/grid_scan_if.sv
// Board input and display drive bundle between the datapath and the scanner.
interface grid_scan_if;
    import grid_scan_pkg::*;

    logic [GRID_W-1:0] grid;
    logic              grid_valid;
    logic [ROWS-1:0]   row_sel;
    logic [COLS-1:0]   col_data;
    logic              frame_done;
    logic              busy;

    modport master (
        output grid, grid_valid,
        input  row_sel, col_data, frame_done, busy
    );

    modport slave (
        input  grid, grid_valid,
        output row_sel, col_data, frame_done, busy
    );

endinterface

// File: rtl/grid_scan_scan_timer.sv
// Phase down-counter: loads a phase length and flags the final cycle of that phase.
module scan_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clka,
    input  logic             stop,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             last_o,
    output logic             last_d_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count; a loaded phase of N cycles starts at N-1 and holds at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i - CNT_W'(1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(negedge clka) begin
        if (stop) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o   = (cnt_q == '0);
    assign last_d_o = (cnt_d == '0);

endmodule

// File: rtl/grid_scan.sv
// Scans a double-buffered 8x8 board onto row/column drivers, one row at a time.
module grid_scan
    import grid_scan_pkg::*;
#(
    parameter int DWELL          = 1000,
    parameter int BLANK          = 16,
    parameter bit ROW_ACTIVE_LOW = 1'b1
) (
    input  logic       clka,
    input  logic       stop,
    grid_scan_if.slave bus
);

    localparam int MAX_PH = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CNT_W  = $clog2(MAX_PH) + 1;
    localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'(BLANK);
    localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    scan_state_e       state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [GRID_W-1:0] pending_q, pending_d;
    logic [GRID_W-1:0] snapshot_q, snapshot_d;
    logic              pend_flag_q, pend_flag_d;
    logic [ROWS-1:0]   row_sel_q, row_sel_d;
    logic [COLS-1:0]   col_data_q, col_data_d;
    logic              frame_done_q, frame_done_d;
    logic              busy_q, busy_d;

    logic              tmr_load_s;
    logic [CNT_W-1:0]  tmr_val_s;
    logic              tmr_last_s;
    logic              tmr_last_d_s;
    logic              boundary_s;

    scan_timer #(.CNT_W(CNT_W)) u_timer (
        .clka       (clka),
        .stop       (stop),
        .load_i     (tmr_load_s),
        .load_val_i (tmr_val_s),
        .last_o     (tmr_last_s),
        .last_d_o   (tmr_last_d_s)
    );

    // Phase sequencing plus the pending/snapshot double buffer.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        pending_d   = pending_q;
        snapshot_d  = snapshot_q;
        pend_flag_d = pend_flag_q;
        tmr_load_s  = 1'b0;
        tmr_val_s   = BLANK_LD;
        boundary_s  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.grid_valid) begin
                    state_d    = S_BLANK;
                    row_d      = '0;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = BLANK_LD;
                    boundary_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BLANK: begin
                if (tmr_last_s) begin
                    state_d    = S_SHOW;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = DWELL_LD;
                end else begin
                    state_d = S_BLANK;
                end
            end
            S_SHOW: begin
                if (tmr_last_s) begin
                    state_d    = S_BLANK;
                    row_d      = row_q + ROW_W'(1);
                    tmr_load_s = 1'b1;
                    tmr_val_s  = BLANK_LD;
                    boundary_s = (row_q == LAST_ROW);
                end else begin
                    state_d = S_SHOW;
                end
            end
            default: begin
                state_d = S_IDLE;
                row_d   = '0;
            end
        endcase

        // A board arriving exactly on a frame boundary bypasses the pending buffer.
        if (boundary_s) begin
            if (bus.grid_valid) begin
                snapshot_d = bus.grid;
            end else if (pend_flag_q) begin
                snapshot_d = pending_q;
            end else begin
                snapshot_d = snapshot_q;
            end
            pend_flag_d = 1'b0;
        end else if (bus.grid_valid) begin
            pending_d   = bus.grid;
            pend_flag_d = 1'b1;
        end else begin
            pend_flag_d = pend_flag_q;
        end
    end

    // Output values derived from the next state so they line up with it once registered.
    always_comb begin
        row_sel_d    = row_off(ROW_ACTIVE_LOW);
        col_data_d   = '0;
        frame_done_d = 1'b0;
        busy_d       = (state_d != S_IDLE);
        if (state_d == S_SHOW) begin
            row_sel_d    = row_on(row_d, ROW_ACTIVE_LOW);
            col_data_d   = snapshot_d[int'(row_d) * COLS +: COLS];
            frame_done_d = (row_d == LAST_ROW) && tmr_last_d_s;
        end else begin
            row_sel_d    = row_off(ROW_ACTIVE_LOW);
            col_data_d   = '0;
            frame_done_d = 1'b0;
        end
    end

    // State, buffers and output registers.
    always_ff @(negedge clka) begin
        if (stop) begin
            state_q      <= S_IDLE;
            row_q        <= '0;
            pending_q    <= '0;
            snapshot_q   <= '0;
            pend_flag_q  <= 1'b0;
            row_sel_q    <= row_off(ROW_ACTIVE_LOW);
            col_data_q   <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            pending_q    <= pending_d;
            snapshot_q   <= snapshot_d;
            pend_flag_q  <= pend_flag_d;
            row_sel_q    <= row_sel_d;
            col_data_q   <= col_data_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.row_sel    = row_sel_q;
    assign bus.col_data   = col_data_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_grid_scan.sv
// Randomized bench for grid_scan against a frame-position reference model.
module tb_grid_scan;

    localparam int D = 4;
    localparam int B = 2;
    localparam int RP = B + D;
    localparam int P = 8 * RP;

    logic clka = 1'b0;
    logic stop = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    // reference model: frame position, displayed board, newest queued board
    bit          run = 1'b0;
    int          pos = 0;
    logic [63:0] disp = 64'h0;
    logic [63:0] newest = 64'h0;
    bit          have_new = 1'b0;

    always #5 clka = ~clka;

    grid_scan_if ifa ();
    grid_scan_if ifb ();

    assign ifb.grid       = ifa.grid;
    assign ifb.grid_valid = ifa.grid_valid;

    grid_scan #(.DWELL(D), .BLANK(B), .ROW_ACTIVE_LOW(1'b1)) dut_a (
        .clka (clka),
        .stop (stop),
        .bus  (ifa.slave)
    );

    grid_scan #(.DWELL(D), .BLANK(B), .ROW_ACTIVE_LOW(1'b0)) dut_b (
        .clka (clka),
        .stop (stop),
        .bus  (ifb.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model, compare all outputs.
    task automatic cycle(input logic s, input logic gv, input logic [63:0] g);
        logic [7:0] onehot;
        logic [7:0] exp_sel;
        logic [7:0] exp_col;
        int         rp;
        int         w;
        bit         show;
        stop           = s;
        ifa.grid_valid = gv;
        ifa.grid       = g;
        @(negedge clka);
        #1;
        if (s) begin
            run = 1'b0; pos = 0; disp = 64'h0; newest = 64'h0; have_new = 1'b0;
        end else if (!run) begin
            if (gv) begin
                run = 1'b1; pos = 0; disp = g;
            end
        end else begin
            pos = (pos + 1) % P;
            if (pos == 0) begin
                if (gv) disp = g;
                else if (have_new) disp = newest;
                have_new = 1'b0;
            end else if (gv) begin
                newest = g; have_new = 1'b1;
            end
        end
        rp      = pos / RP;
        w       = pos % RP;
        show    = run && (w >= B);
        onehot  = 8'd1 << rp;
        exp_sel = show ? ~onehot : 8'hFF;
        exp_col = show ? disp[rp*8 +: 8] : 8'h00;
        chk("row_sel_al", 64'(ifa.row_sel), 64'(exp_sel));
        chk("row_sel_ah", 64'(ifb.row_sel), 64'(show ? onehot : 8'h00));
        chk("col_data", 64'(ifa.col_data), 64'(exp_col));
        chk("col_data_b", 64'(ifb.col_data), 64'(exp_col));
        chk("frame_done", 64'(ifa.frame_done), 64'(show && rp == 7 && w == RP - 1));
        chk("busy", 64'(ifa.busy), 64'(run));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 64'h0);
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < 2 * P && pos != target; i++) cycle(1'b0, 1'b0, 64'h0);
    endtask

    initial begin
        logic [63:0] g35;
        logic [63:0] rg;
        ifa.grid_valid = 1'b0;
        ifa.grid       = 64'h0;

        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 64'h0);
        idle_cycles(100);

        // single-pixel corners
        cycle(1'b0, 1'b1, 64'h8000_0000_0000_0001);
        chk("blank_ah_const", 64'(ifb.row_sel), 64'h00);
        run_to(B);
        chk("r0_sel_const", 64'(ifa.row_sel), 64'hFE);
        chk("r0_col_const", 64'(ifa.col_data), 64'h01);
        chk("r0_ah_const", 64'(ifb.row_sel), 64'h01);
        run_to(7 * RP + B);
        chk("r7_sel_const", 64'(ifa.row_sel), 64'h7F);
        chk("r7_col_const", 64'(ifa.col_data), 64'h80);
        idle_cycles(2 * P);

        // two boards within one frame collapse to the last one
        run_to(3 * RP + B);
        cycle(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        cycle(1'b0, 1'b0, 64'h0);
        cycle(1'b0, 1'b1, 64'h0);
        idle_cycles(2 * P);

        // board arriving on the frame boundary
        g35 = {$urandom, $urandom};
        run_to(P - 1);
        cycle(1'b0, 1'b1, g35);
        run_to(B);
        chk("coin_r0_col", 64'(ifa.col_data), 64'(g35[7:0]));
        idle_cycles(P);

        // stop during row 5 dwell
        run_to(5 * RP + B + 1);
        cycle(1'b1, 1'b0, 64'h0);
        chk("stop_sel_const", 64'(ifa.row_sel), 64'hFF);
        chk("stop_busy_const", 64'(ifa.busy), 64'h0);
        idle_cycles(60);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            rg = {$urandom, $urandom};
            cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 19) == 0), rg);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/grid_scan.md
GRID_SCAN -- requirements
Module: grid_scan

Interface
REQ-001 Parameter DWELL, default 1000, clka cycles a row is lit; legal range >=1.
REQ-002 Parameter BLANK, default 16, clka cycles all rows are off between rows; legal range >=1.
REQ-003 Parameter ROW_ACTIVE_LOW, default 1, selects row_sel polarity (1 = active-low).
REQ-004 clka  input  1  sole clock; all logic on negedge clka, matching the datapath's clock.
REQ-005 stop  input  1  synchronous active-high reset, sampled on negedge clka.
REQ-006 grid  input  64  board from the datapath; bit r*8+c is row r, column c; bit 0 is top-left.
REQ-007 grid_valid  input  1  one-cycle pulse: grid holds a new generation.
REQ-008 row_sel  output  8  one-hot row drive, or all-off, in ROW_ACTIVE_LOW polarity.
REQ-009 col_data  output  8  active-high column data for the lit row; col_data[c] = cell (row, c).
REQ-010 frame_done  output  1  one-cycle pulse at the end of row 7's dwell.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 FSM states:
- IDLE: display dark, no snapshot.
- BLANK: all rows off.
- SHOW: one row lit.
REQ-013 IDLE -> BLANK (row 0) on the cycle after the first grid_valid.
REQ-014 BLANK lasts exactly BLANK cycles, then goes to SHOW for the same row.
REQ-015 SHOW lasts exactly DWELL cycles.
- Rows 0-6: SHOW -> BLANK with row index +1.
- Row 7: SHOW -> BLANK with row index wrapping to 0.
REQ-016 Frame period is 8*(BLANK+DWELL) cycles; no dead cycles between rows or frames.
REQ-017 During SHOW of row r:
- row_sel has only bit r active.
- col_data = snapshot[r*8+7 : r*8].
REQ-018 In IDLE and BLANK:
- row_sel is all inactive: 8'hFF if ROW_ACTIVE_LOW, else 8'h00.
- col_data = 0.
REQ-019 Two 64-bit registers are kept: pending and snapshot.
- On grid_valid, pending <= grid and pend_flag is set.
REQ-020 Snapshot loads from pending only at a frame boundary, then pend_flag clears. A frame boundary is either:
- the IDLE->BLANK transition, or
- the last SHOW cycle of row 7.
REQ-021 Multiple grid_valid pulses within one frame collapse: the last grid value wins, and no frame shows torn or mixed data.
REQ-022 grid_valid on the same cycle as a frame boundary: that grid value goes to snapshot directly, and pend_flag stays clear.
REQ-023 Without a new grid_valid the current snapshot is redisplayed indefinitely.
REQ-024 frame_done is high only on the last SHOW cycle of row 7; it is never high in IDLE.
REQ-025 Counter width is $clog2(max(DWELL,BLANK))+1 bits; counters never wrap mid-phase.
REQ-026 All outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-027 While stop=1 at a negedge clka, the next state is:
- FSM = IDLE, row index = 0, counters = 0;
- pending = 0, snapshot = 0, pend_flag = 0;
- row_sel = all inactive, col_data = 0, frame_done = 0, busy = 0.
REQ-028 stop asserted mid-frame abandons the frame at once; no frame_done is issued.
REQ-029 stop has priority over a simultaneous grid_valid, which is discarded.

Structure
REQ-030 A shared package holds:
- the FSM state enum (IDLE, BLANK, SHOW);
- GRID_W=64, ROWS=8, COLS=8;
- the inactive-row constant function of ROW_ACTIVE_LOW.
REQ-031 One sub-module, scan_timer, holds the phase down-counter, loads BLANK or DWELL, and flags the last cycle; the FSM and buffers stay in grid_scan.

Verification (DWELL=4, BLANK=2, ROW_ACTIVE_LOW=1 unless noted)
REQ-032 stop high, then low with no grid_valid for 100 cycles -> row_sel=8'hFF, col_data=0, busy=0, frame_done never pulses.
REQ-033 grid=64'h8000_0000_0000_0001 plus one grid_valid:
- row 0 SHOW: row_sel=8'hFE, col_data=8'h01;
- row 7 SHOW: row_sel=8'h7F, col_data=8'h80;
- frame_done every 48 cycles.
REQ-034 Mid-frame (row 3): grid_valid with grid=all-ones, then grid_valid with grid=64'h0 two cycles later -> current frame unchanged; next frame shows all zeros; no all-ones frame is ever shown.
REQ-035 grid_valid coincident with the row-7 last SHOW cycle -> next frame's row 0 shows the new grid; pend_flag remains 0.
REQ-036 stop pulsed during row 5 SHOW -> next negedge row_sel=8'hFF, busy=0, no frame_done; display stays dark until the next grid_valid.
REQ-037 With ROW_ACTIVE_LOW=0 and the REQ-033 stimulus, row 0 SHOW gives row_sel=8'h01, and BLANK gives row_sel=8'h00.
